// File: rtl/adc_cap_pkg.sv
// Shared state encoding and default slot positions for the codec ADC capture block.
package adc_cap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FRAME,
      CAPTURE,
      PUSH
   } capState_e;

   localparam int DEF_LEFT_START  = 15;
   localparam int DEF_RIGHT_START = 47;
   localparam int DEF_SAMPLE_BITS = 16;

   localparam logic [6:0]  CNT_MAX = 7'd127;
   localparam logic [15:0] OVF_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous codec line, with rise/fall detect
// against a registered copy of the synchronised level.
module sync_edge (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic sig_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= sig_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/adc_wave_capture.sv
// Captures one stereo word per codec ADC frame and pushes it downstream.
// Define REC_OVF_CNT_EN to build the 16-bit overrun counter; otherwise ovf_cnt is 0.
module adc_wave_capture
   import adc_cap_pkg::*;
#(
   parameter int LEFT_START  = DEF_LEFT_START,
   parameter int RIGHT_START = DEF_RIGHT_START,
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
) (
   input  logic        clock_50M,
   input  logic        reset_n,
   input  logic        bclk,
   input  logic        adclrc,
   input  logic        adcdat,
   input  logic        rec_en,
   input  logic        wav_full,
   output logic        wav_wren,
   output logic [31:0] wav_in_data,
   output logic        frame_err,
   output logic        ovf_flag,
   output logic [15:0] ovf_cnt
);

   localparam logic [6:0] LEFT_LO  = 7'(LEFT_START);
   localparam logic [6:0] LEFT_HI  = 7'(LEFT_START + SAMPLE_BITS);
   localparam logic [6:0] RIGHT_LO = 7'(RIGHT_START);
   localparam logic [6:0] RIGHT_HI = 7'(RIGHT_START + SAMPLE_BITS);
   localparam logic [6:0] LAST_BIT = 7'(RIGHT_START + SAMPLE_BITS - 1);

   capState_e   state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [15:0] left_q, left_d;
   logic [15:0] right_q, right_d;
   logic [31:0] data_q, data_d;
   logic        wren_q, wren_d;
   logic        err_q, err_d;
   logic        ovfFlag_q, ovfFlag_d;
   logic        recEnPrev_q;
   logic        datMeta_q, datSync_q;
   logic        bclkSync, bclkRise, bclkFall;
   logic        lrcSync, lrcRise, lrcFall;
   logic        unusedSync;
`ifdef REC_OVF_CNT_EN
   logic [15:0] ovfCnt_q, ovfCnt_d;
`endif

   sync_edge uBclkSync (
      .clk_i   (clock_50M),
      .rst_n_i (reset_n),
      .sig_i   (bclk),
      .sync_o  (bclkSync),
      .rise_o  (bclkRise),
      .fall_o  (bclkFall)
   );

   sync_edge uLrcSync (
      .clk_i   (clock_50M),
      .rst_n_i (reset_n),
      .sig_i   (adclrc),
      .sync_o  (lrcSync),
      .rise_o  (lrcRise),
      .fall_o  (lrcFall)
   );

   assign unusedSync = bclkSync | bclkFall | lrcSync | lrcFall;

   // A frame edge always wins over a bit edge: it either starts a frame or restarts a short one.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      right_d   = right_q;
      data_d    = data_q;
      wren_d    = 1'b0;
      err_d     = 1'b0;
      ovfFlag_d = ovfFlag_q;
`ifdef REC_OVF_CNT_EN
      ovfCnt_d  = ovfCnt_q;
`endif
      if (rec_en && !recEnPrev_q) begin
         ovfFlag_d = 1'b0;
`ifdef REC_OVF_CNT_EN
         ovfCnt_d  = '0;
`endif
      end
      if (!rec_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: state_d = WAIT_FRAME;
            WAIT_FRAME: begin
               if (lrcRise) begin
                  state_d = CAPTURE;
                  cnt_d   = '0;
                  left_d  = '0;
                  right_d = '0;
               end
            end
            CAPTURE: begin
               if (lrcRise) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  left_d  = '0;
                  right_d = '0;
               end else if (cnt_q == CNT_MAX) begin
                  err_d   = 1'b1;
                  state_d = WAIT_FRAME;
               end else if (bclkRise) begin
                  if (cnt_q >= LEFT_LO && cnt_q < LEFT_HI)
                     left_d = {left_q[14:0], datSync_q};
                  if (cnt_q >= RIGHT_LO && cnt_q < RIGHT_HI)
                     right_d = {right_q[14:0], datSync_q};
                  cnt_d = cnt_q + 7'd1;
                  if (cnt_q == LAST_BIT)
                     state_d = PUSH;
               end
            end
            PUSH: begin
               state_d = WAIT_FRAME;
               if (wav_full) begin
                  ovfFlag_d = 1'b1;
`ifdef REC_OVF_CNT_EN
                  if (ovfCnt_q != OVF_MAX)
                     ovfCnt_d = ovfCnt_q + 16'd1;
`endif
               end else begin
                  wren_d = 1'b1;
                  data_d = {left_q, right_q};
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_50M or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         left_q      <= '0;
         right_q     <= '0;
         data_q      <= '0;
         wren_q      <= 1'b0;
         err_q       <= 1'b0;
         ovfFlag_q   <= 1'b0;
         recEnPrev_q <= 1'b0;
         datMeta_q   <= 1'b0;
         datSync_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         right_q     <= right_d;
         data_q      <= data_d;
         wren_q      <= wren_d;
         err_q       <= err_d;
         ovfFlag_q   <= ovfFlag_d;
         recEnPrev_q <= rec_en;
         datMeta_q   <= adcdat;
         datSync_q   <= datMeta_q;
      end
   end

`ifdef REC_OVF_CNT_EN
   always_ff @(posedge clock_50M or negedge reset_n) begin
      if (!reset_n)
         ovfCnt_q <= '0;
      else
         ovfCnt_q <= ovfCnt_d;
   end
   assign ovf_cnt = ovfCnt_q;
`else
   assign ovf_cnt = 16'h0000;
`endif

   assign wav_wren    = wren_q;
   assign wav_in_data = data_q;
   assign frame_err   = err_q;
   assign ovf_flag    = ovfFlag_q;

endmodule

// File: tb/tb_adc_wave_capture.sv
// Directed bench for adc_wave_capture; expected overrun counts follow REC_OVF_CNT_EN.
module tb_adc_wave_capture;

   logic        clock_50M = 1'b0;
   logic        reset_n;
   logic        bclk;
   logic        adclrc;
   logic        adcdat;
   logic        rec_en;
   logic        wav_full;
   logic        wav_wren;
   logic [31:0] wav_in_data;
   logic        frame_err;
   logic        ovf_flag;
   logic [15:0] ovf_cnt;

   int passCount  = 0;
   int checkCount = 0;
   int wrenCount  = 0;
   int errCount   = 0;

`ifdef REC_OVF_CNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   adc_wave_capture dut (
      .clock_50M   (clock_50M),
      .reset_n     (reset_n),
      .bclk        (bclk),
      .adclrc      (adclrc),
      .adcdat      (adcdat),
      .rec_en      (rec_en),
      .wav_full    (wav_full),
      .wav_wren    (wav_wren),
      .wav_in_data (wav_in_data),
      .frame_err   (frame_err),
      .ovf_flag    (ovf_flag),
      .ovf_cnt     (ovf_cnt)
   );

   // 50 MHz system clock
   always #10 clock_50M = ~clock_50M;

   // Count cycles in which the one-cycle strobes are high
   always @(negedge clock_50M) begin
      if (wav_wren === 1'b1) wrenCount++;
      if (frame_err === 1'b1) errCount++;
   end

   function automatic logic [31:0] expCnt(input int n);
      return (CNT_EN != 0) ? 32'(n) : 32'd0;
   endfunction

   function automatic logic frameBit(input logic [15:0] l, input logic [15:0] r, input int k);
      if (k >= 15 && k < 31) return l[30-k];
      if (k >= 47 && k < 63) return r[62-k];
      return 1'((k / 3) & 1);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One bclk period (clock_50M/32); data and adclrc change on the falling bclk edge
   task automatic driveBit(input logic dat, input logic lrc);
      bclk   = 1'b0;
      adcdat = dat;
      adclrc = lrc;
      repeat (16) @(negedge clock_50M);
      bclk = 1'b1;
      repeat (16) @(negedge clock_50M);
   endtask

   // act: 0 none, 1 drop rec_en at bit actAt, 2 pulse reset_n at bit actAt
   task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int nBits,
                                input int actAt, input int act);
      for (int k = 0; k < nBits; k++) begin
         if (k == actAt && act == 1) rec_en = 1'b0;
         if (k == actAt && act == 2) begin
            reset_n = 1'b0;
            #1;
            checkOutput("rstmid_wren", 32'(wav_wren), 32'd0);
            checkOutput("rstmid_data", wav_in_data, 32'd0);
            checkOutput("rstmid_err", 32'(frame_err), 32'd0);
            checkOutput("rstmid_flag", 32'(ovf_flag), 32'd0);
            checkOutput("rstmid_cnt", 32'(ovf_cnt), 32'd0);
            repeat (3) @(negedge clock_50M);
            reset_n = 1'b1;
         end
         driveBit(frameBit(l, r, k), (k < nBits / 2));
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      bclk     = 1'b0;
      adclrc   = 1'b0;
      adcdat   = 1'b0;
      rec_en   = 1'b0;
      wav_full = 1'b0;
      repeat (2) @(negedge clock_50M);
      checkOutput("rst_wren", 32'(wav_wren), 32'd0);
      checkOutput("rst_data", wav_in_data, 32'd0);
      checkOutput("rst_err", 32'(frame_err), 32'd0);
      checkOutput("rst_flag", 32'(ovf_flag), 32'd0);
      checkOutput("rst_cnt", 32'(ovf_cnt), 32'd0);
      reset_n = 1'b1;
      @(negedge clock_50M);
      rec_en = 1'b1;
      repeat (4) @(negedge clock_50M);

      $display("[TB] normal frame");
      applyStimulus(16'hA5C3, 16'h3C5A, 64, -1, 0);
      checkOutput("norm_wrens", 32'(wrenCount), 32'd1);
      checkOutput("norm_data", wav_in_data, 32'hA5C33C5A);
      checkOutput("norm_errs", 32'(errCount), 32'd0);
      checkOutput("norm_flag", 32'(ovf_flag), 32'd0);

      $display("[TB] frames into full buffer");
      wav_full = 1'b1;
      applyStimulus(16'h1111, 16'h2222, 64, -1, 0);
      checkOutput("full1_wrens", 32'(wrenCount), 32'd1);
      checkOutput("full1_flag", 32'(ovf_flag), 32'd1);
      checkOutput("full1_cnt", 32'(ovf_cnt), expCnt(1));
      applyStimulus(16'h3333, 16'h4444, 64, -1, 0);
      checkOutput("full2_wrens", 32'(wrenCount), 32'd1);
      checkOutput("full2_flag", 32'(ovf_flag), 32'd1);
      checkOutput("full2_cnt", 32'(ovf_cnt), expCnt(2));
      checkOutput("full2_hold", wav_in_data, 32'hA5C33C5A);
      wav_full = 1'b0;

      $display("[TB] short frame then full frame");
      applyStimulus(16'hFFFF, 16'hFFFF, 30, -1, 0);
      applyStimulus(16'h1234, 16'hABCD, 64, -1, 0);
      checkOutput("short_errs", 32'(errCount), 32'd1);
      checkOutput("short_wrens", 32'(wrenCount), 32'd2);
      checkOutput("short_data", wav_in_data, 32'h1234ABCD);

      $display("[TB] rec_en dropped mid-frame");
      applyStimulus(16'h7777, 16'h8888, 64, 40, 1);
      checkOutput("drop_wrens", 32'(wrenCount), 32'd2);
      checkOutput("drop_flag", 32'(ovf_flag), 32'd1);
      checkOutput("drop_cnt", 32'(ovf_cnt), expCnt(2));
      rec_en = 1'b1;
      repeat (3) @(negedge clock_50M);
      checkOutput("rise_flag", 32'(ovf_flag), 32'd0);
      checkOutput("rise_cnt", 32'(ovf_cnt), 32'd0);
      applyStimulus(16'h5555, 16'hAAAA, 64, -1, 0);
      checkOutput("resume_wrens", 32'(wrenCount), 32'd3);
      checkOutput("resume_data", wav_in_data, 32'h5555AAAA);

      $display("[TB] reset pulsed mid-frame");
      applyStimulus(16'h0F0F, 16'hF0F0, 64, 50, 2);
      checkOutput("rstfrm_wrens", 32'(wrenCount), 32'd3);
      applyStimulus(16'hC3A5, 16'h5AC3, 64, -1, 0);
      checkOutput("rstnext_wrens", 32'(wrenCount), 32'd4);
      checkOutput("rstnext_data", wav_in_data, 32'hC3A55AC3);
      checkOutput("final_errs", 32'(errCount), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/adc_wave_capture.md
ADC_WAVE_CAPTURE -- requirements
Module: adc_wave_capture

Interface
REQ-001 SHALL have parameter LEFT_START, default 15, meaning the bclk-rising-edge index (0-based, after the adclrc rising edge) of the left-channel MSB.
REQ-002 SHALL have parameter RIGHT_START, default 47, meaning the bclk-rising-edge index of the right-channel MSB.
REQ-003 SHALL have parameter SAMPLE_BITS, default 16, meaning the bits captured per channel.
REQ-004 SHALL have port clock_50M, input, 1, the single system clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have ports bclk (input, 1, codec bit clock), adclrc (input, 1, codec ADC frame/channel clock) and adcdat (input, 1, codec serial ADC data).
REQ-007 SHALL have port rec_en, input, 1, the record enable.
REQ-008 SHALL have port wav_full, input, 1, high when the downstream buffer cannot accept a word.
REQ-009 SHALL have ports wav_wren (output, 1, one-cycle write strobe) and wav_in_data (output, 32, {left[15:0], right[15:0]}).
REQ-010 SHALL have ports frame_err (output, 1, one-cycle malformed-frame pulse), ovf_flag (output, 1, sticky overrun flag) and ovf_cnt (output, 16, overrun count).

Function
REQ-011 SHALL synchronise bclk, adclrc and adcdat through two clock_50M flops each, with equal delay, and detect edges on the synchronised copies.
REQ-012 SHALL use a state machine with states IDLE, WAIT_FRAME, CAPTURE and PUSH.
REQ-013 SHALL stay in IDLE while rec_en=0, and SHALL go to WAIT_FRAME when rec_en=1.
REQ-014 SHALL, on an adclrc rising edge in WAIT_FRAME, enter CAPTURE with the bit counter at 0 and the shift register cleared.
REQ-015 SHALL, in CAPTURE, sample the synchronised adcdat on each bclk rising edge and then increment the 7-bit bit counter, which saturates at 127.
REQ-016 SHALL shift the sample MSB-first into the left half when LEFT_START <= count < LEFT_START+SAMPLE_BITS, and into the right half when RIGHT_START <= count < RIGHT_START+SAMPLE_BITS; samples at all other counts are ignored.
REQ-017 SHALL enter PUSH on the clock after the sample taken at count RIGHT_START+SAMPLE_BITS-1.
REQ-018 SHALL, in PUSH with wav_full=0, assert wav_wren for exactly one clock with wav_in_data valid in that same cycle, and then return to WAIT_FRAME.
REQ-019 SHALL, in PUSH with wav_full=1, drop the word, keep wav_wren low, set ovf_flag, increment ovf_cnt (saturating at 16'hFFFF), and return to WAIT_FRAME.
REQ-020 SHALL treat an adclrc rising edge in CAPTURE before the frame completes as a short frame: pulse frame_err for one clock, discard the partial word, and restart CAPTURE at count 0 on that same edge.
REQ-021 SHALL treat the bit counter reaching saturation (127) in CAPTURE as a long frame: pulse frame_err, discard the word, and go to WAIT_FRAME.
REQ-022 SHALL, when rec_en falls in any state, go to IDLE on the next clock without writing; ovf_flag and ovf_cnt hold their values.
REQ-023 SHALL clear ovf_flag and ovf_cnt only on the rising edge of rec_en.
REQ-024 SHALL hold wav_in_data stable from one write until the next write.

Reset
REQ-025 SHALL, on asserting reset_n=0, immediately force: state IDLE, bit counter 0, shift register 0, synchroniser flops 0, wav_wren 0, wav_in_data 0, frame_err 0, ovf_flag 0, ovf_cnt 0.
REQ-026 SHALL, when reset asserts mid-frame, produce no write; after release, capture begins only on a fresh adclrc rising edge.

Configuration
REQ-027 SHALL, with REC_OVF_CNT_EN defined, implement the 16-bit ovf_cnt counter.
REQ-028 SHALL, without REC_OVF_CNT_EN defined, drive ovf_cnt constant 0; ovf_flag is unaffected.

Structure
REQ-029 SHALL place the state encoding and default slot constants (15, 47, 16) in the shared package adc_cap_pkg.
REQ-030 SHALL use one sub-module, sync_edge, instantiated for bclk and adclrc to provide a 2-flop synchroniser plus registered rise/fall detect; adcdat SHALL use a matching 2-flop delay.

Verification
REQ-031 SHALL cover: bclk = clock_50M/32, left=16'hA5C3, right=16'h3C5A, wav_full=0 -> exactly one wav_wren pulse with wav_in_data=32'hA5C33C5A.
REQ-032 SHALL cover: the same frame with wav_full=1 -> no wav_wren, ovf_flag=1, ovf_cnt=1; a second full frame -> ovf_cnt=2.
REQ-033 SHALL cover: an adclrc rising edge at bit count 30 -> one frame_err pulse, no write, and the next complete frame captured correctly.
REQ-034 SHALL cover: rec_en dropped at bit count 40, then raised -> no write, ovf_flag/ovf_cnt cleared on the rise, normal capture resumes.
REQ-035 SHALL cover: reset_n pulsed low at bit count 50 -> all outputs 0 immediately, and the first write occurs only after the next full frame.
REQ-036 SHALL cover: a build without REC_OVF_CNT_EN and the scenario of REQ-032 -> ovf_flag=1, ovf_cnt=0.
